// File: rtl/cpu_hatch_pkg.sv
// Shared types and widths for the two-entry instruction hatch between a CPU
// fetch port and a 16-bit-wide instruction memory.
package cpu_hatch_pkg;

    localparam int INSTR_W = 48;
    localparam int BEAT_W  = 16;
    localparam int BEATS   = 3;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_BEAT2
    } hatch_state_e;

    // First 16-bit memory word of an instruction index (index * 3, wrapping).
    function automatic logic [ADDR_W-1:0] beat_base(input logic [ADDR_W-1:0] tag);
        return tag + (tag << 1);
    endfunction

endpackage

// File: rtl/cpu_hatch_bridge_if.sv
// Fetch-side and memory-side signals of the hatch bridge, bundled as one port.
interface cpu_hatch_bridge_if;
    import cpu_hatch_pkg::*;

    logic [ADDR_W-1:0]  hatch_address;
    logic [INSTR_W-1:0] hatch_instruction;
    logic               hatch_valid;
    logic               flush;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [BEAT_W-1:0]  mem_rdata;

    modport slave (
        input  hatch_address, flush, mem_ack, mem_rdata,
        output hatch_instruction, hatch_valid, mem_req, mem_addr
    );

    modport master (
        output hatch_address, flush, mem_ack, mem_rdata,
        input  hatch_instruction, hatch_valid, mem_req, mem_addr
    );

endinterface

// File: rtl/cpu_hatch_entry.sv
// One buffered instruction: valid bit, tag, three 16-bit beats and a tag compare.
module cpu_hatch_entry
    import cpu_hatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inval,
    input  logic               beat_we,
    input  logic [1:0]         beat_sel,
    input  logic [BEAT_W-1:0]  beat_data,
    input  logic               commit,
    input  logic [ADDR_W-1:0]  commit_tag,
    input  logic [ADDR_W-1:0]  cmp_addr,
    output logic               valid,
    output logic [ADDR_W-1:0]  tag,
    output logic [INSTR_W-1:0] data,
    output logic               hit
);

    logic              valid_reg;
    logic [ADDR_W-1:0] tag_reg;

    // Invalidate beats commit so a flush landing on the last beat leaves the entry empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
        end else if (inval) begin
            valid_reg <= 1'b0;
        end else if (commit) begin
            valid_reg <= 1'b1;
            tag_reg   <= commit_tag;
        end
    end

    // Beat 0 is the most significant halfword.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            logic [BEAT_W-1:0] beat_reg;

            always_ff @(posedge clk) begin
                if (beat_we && beat_sel == 2'(gi)) begin
                    beat_reg <= beat_data;
                end
            end

            assign data[INSTR_W-1-gi*BEAT_W -: BEAT_W] = beat_reg;
        end
    endgenerate

    assign valid = valid_reg;
    assign tag   = tag_reg;
    assign hit   = valid_reg && (tag_reg == cmp_addr);

endmodule

// File: rtl/cpu_hatch_bridge.sv
// Two-entry instruction hatch: combinational hit path, 3-beat demand fills from
// 16-bit memory, next-index prefetch, and beat-boundary abort on miss or flush.
module cpu_hatch_bridge
    import cpu_hatch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = 48'h0
) (
    input  logic              clk,
    input  logic              rst,
    cpu_hatch_bridge_if.slave bus
);

    hatch_state_e      state_reg;
    logic [ADDR_W-1:0] fill_tag_reg;
    logic [ADDR_W-1:0] pf_tag_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              fill_entry_reg;
    logic              fill_demand_reg;
    logic              abort_reg;
    logic              pf_pending_reg;
    logic              pf_entry_reg;
    logic              lru_reg;
    logic              mem_req_reg;

    logic [1:0]         entry_valid;
    logic [1:0]         entry_hit;
    logic [1:0]         entry_inval;
    logic [1:0]         entry_we;
    logic [1:0]         entry_commit;
    logic [ADDR_W-1:0]  entry_tag  [2];
    logic [INSTR_W-1:0] entry_data [2];

    logic [1:0]        beat_sel;
    logic              busy;
    logic              hit_any;
    logic              hit_idx;
    logic              addr_miss;
    logic              dup_now;
    logic              abort_now;
    logic              beat_done;
    logic              complete;
    logic              pf_known;
    logic              demand_start;
    logic              pf_start;
    logic              fill_start;
    logic              start_entry;
    logic [ADDR_W-1:0] start_tag;

    always_comb begin
        beat_sel = 2'd0;
        case (state_reg)
            ST_BEAT1: beat_sel = 2'd1;
            ST_BEAT2: beat_sel = 2'd2;
            default:  beat_sel = 2'd0;
        endcase
    end

    assign busy    = (state_reg != ST_IDLE);
    assign hit_any = |entry_hit;
    assign hit_idx = entry_hit[1] & ~entry_hit[0];

    // A fetch that hits neither an entry nor the in-flight tag means the CPU has moved on.
    assign addr_miss = !hit_any && (bus.hatch_address != fill_tag_reg);
    assign dup_now   = entry_valid[~fill_entry_reg] && (entry_tag[~fill_entry_reg] == fill_tag_reg);
    assign abort_now = busy && (bus.flush || abort_reg || dup_now || addr_miss);
    assign beat_done = busy && bus.mem_ack;
    assign complete  = beat_done && (state_reg == ST_BEAT2) && !abort_now;

    assign pf_known = (entry_valid[0] && entry_tag[0] == pf_tag_reg) ||
                      (entry_valid[1] && entry_tag[1] == pf_tag_reg);

    // Demand misses always take the machine; the queued prefetch only runs on a hit cycle.
    assign demand_start = !busy && !hit_any;
    assign pf_start     = !busy && hit_any && pf_pending_reg && !bus.flush && !pf_known;
    assign fill_start   = demand_start || pf_start;
    assign start_entry  = demand_start ? lru_reg : pf_entry_reg;
    assign start_tag    = demand_start ? bus.hatch_address : pf_tag_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            assign entry_inval[gi]  = bus.flush || (fill_start && start_entry == 1'(gi));
            assign entry_we[gi]     = beat_done && (fill_entry_reg == 1'(gi));
            assign entry_commit[gi] = complete && (fill_entry_reg == 1'(gi));

            cpu_hatch_entry u_entry (
                .clk        (clk),
                .rst        (rst),
                .inval      (entry_inval[gi]),
                .beat_we    (entry_we[gi]),
                .beat_sel   (beat_sel),
                .beat_data  (bus.mem_rdata),
                .commit     (entry_commit[gi]),
                .commit_tag (fill_tag_reg),
                .cmp_addr   (bus.hatch_address),
                .valid      (entry_valid[gi]),
                .tag        (entry_tag[gi]),
                .data       (entry_data[gi]),
                .hit        (entry_hit[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            fill_tag_reg    <= '0;
            pf_tag_reg      <= '0;
            mem_addr_reg    <= '0;
            fill_entry_reg  <= 1'b0;
            fill_demand_reg <= 1'b0;
            abort_reg       <= 1'b0;
            pf_pending_reg  <= 1'b0;
            pf_entry_reg    <= 1'b0;
            lru_reg         <= 1'b0;
            mem_req_reg     <= 1'b0;
        end else begin
            if (hit_any) begin
                lru_reg <= ~hit_idx;
            end

            case (state_reg)
                ST_IDLE: begin
                    // A pending prefetch gets exactly one chance from IDLE.
                    pf_pending_reg <= 1'b0;
                    if (fill_start) begin
                        state_reg       <= ST_BEAT0;
                        mem_req_reg     <= 1'b1;
                        mem_addr_reg    <= beat_base(start_tag);
                        fill_tag_reg    <= start_tag;
                        fill_entry_reg  <= start_entry;
                        fill_demand_reg <= demand_start;
                        abort_reg       <= 1'b0;
                    end
                end
                default: begin
                    if (beat_done) begin
                        if (abort_now || state_reg == ST_BEAT2) begin
                            state_reg   <= ST_IDLE;
                            mem_req_reg <= 1'b0;
                            abort_reg   <= 1'b0;
                        end else begin
                            state_reg    <= (state_reg == ST_BEAT0) ? ST_BEAT1 : ST_BEAT2;
                            mem_addr_reg <= mem_addr_reg + 1'b1;
                        end
                        if (complete && fill_demand_reg) begin
                            pf_pending_reg <= 1'b1;
                            pf_tag_reg     <= fill_tag_reg + 1'b1;
                            pf_entry_reg   <= ~fill_entry_reg;
                        end
                    end else if (bus.flush || dup_now) begin
                        // Remember one-cycle abort causes until the stalled beat is accepted.
                        abort_reg <= 1'b1;
                    end
                end
            endcase

            if (bus.flush) begin
                pf_pending_reg <= 1'b0;
            end
        end
    end

    assign bus.mem_req           = mem_req_reg;
    assign bus.mem_addr          = mem_addr_reg;
    assign bus.hatch_valid       = hit_any;
    assign bus.hatch_instruction = hit_any ? entry_data[hit_idx] : NOP_INSTR;

endmodule
